// File: rtl/wdt_ctrl.sv
// wdt_ctrl: bus-side register port and sequencer for the clk2-domain watchdog timer.
// Optional feature macro WDT_LOCK_EN: enable becomes sticky after the first arm.
module wdt_ctrl #(
   parameter int unsigned LIVE_HOLD = 16,
   parameter int unsigned SETTLE    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [3:0]  addr,
   input  logic [31:0] wdata,
   output logic        ack,
   output logic [31:0] rdata,
   input  logic        wto_in,
   output logic        WDEN,
   output logic        WDLIVE,
   output logic [31:0] WTOCNT,
   output logic        irq
);

   localparam int unsigned MAX_CNT = (LIVE_HOLD > SETTLE) ? LIVE_HOLD : SETTLE;
   localparam int unsigned CW      = $clog2(MAX_CNT) + 1;
   localparam logic [CW-1:0] LIVE_LOAD   = CW'(LIVE_HOLD);
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE);
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);

   localparam logic [3:0] ADDR_CTRL   = 4'h0;
   localparam logic [3:0] ADDR_KICK   = 4'h4;
   localparam logic [3:0] ADDR_TOCNT  = 4'h8;
   localparam logic [3:0] ADDR_STATUS = 4'hC;

   typedef enum logic [2:0] {StDis, StArm, StRun, StKick, StStop} state_e;

   state_e        r_state, w_state_d;
   logic [CW-1:0] r_cnt, w_cnt_d;
   logic          r_pend_en, w_pend_en_d;
   logic          r_pend_dis, w_pend_dis_d;
   logic          r_wden, r_wdlive;
   logic [31:0]   r_tocnt;
   logic          r_ack;
   logic [31:0]   r_rdata, w_rdata;
   logic          r_sync1, r_sync2, r_wto_prev;
   logic          r_sticky, r_cfg_err;

   logic          w_wr, w_wr_ctrl, w_wr_kick, w_wr_tocnt, w_wr_status;
   logic          w_en_req, w_dis_req, w_lock_viol, w_lock;
   logic          w_wto_rise, w_cfg_set, w_busy;
   logic [1:0]    w_code;

   // Access decode
   assign w_wr        = req & we;
   assign w_wr_ctrl   = w_wr & (addr == ADDR_CTRL);
   assign w_wr_kick   = w_wr & (addr == ADDR_KICK) & wdata[0];
   assign w_wr_tocnt  = w_wr & (addr == ADDR_TOCNT);
   assign w_wr_status = w_wr & (addr == ADDR_STATUS);

   assign w_en_req    = w_wr_ctrl & wdata[0];
   assign w_dis_req   = w_wr_ctrl & ~wdata[0] & ~w_lock;
   assign w_lock_viol = w_wr_ctrl & ~wdata[0] & w_lock;

`ifdef WDT_LOCK_EN
   logic r_lock;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lock <= 1'b0;
      end else if (w_state_d == StArm) begin
         r_lock <= 1'b1;
      end
   end

   assign w_lock = r_lock;
`else
   assign w_lock = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= StDis;
         r_cnt      <= '0;
         r_pend_en  <= 1'b0;
         r_pend_dis <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_cnt      <= w_cnt_d;
         r_pend_en  <= w_pend_en_d;
         r_pend_dis <= w_pend_dis_d;
      end
   end

   // FSM next state; counters load on entry and expire when they reach 1
   always_comb begin
      w_state_d    = r_state;
      w_cnt_d      = r_cnt;
      w_pend_en_d  = r_pend_en;
      w_pend_dis_d = r_pend_dis;
      case (r_state)
         StDis: begin
            w_pend_dis_d = 1'b0;
            if (w_en_req || r_pend_en) begin
               w_state_d   = StArm;
               w_cnt_d     = SETTLE_LOAD;
               w_pend_en_d = 1'b0;
            end
         end
         StArm: begin
            // A disable during ARM is held until WDEN has settled high
            if (w_dis_req) begin
               w_pend_dis_d = 1'b1;
            end
            if (r_cnt == CNT_ONE) begin
               if (r_pend_dis || w_dis_req) begin
                  w_state_d    = StStop;
                  w_cnt_d      = SETTLE_LOAD;
                  w_pend_dis_d = 1'b0;
               end else begin
                  w_state_d = StRun;
               end
            end else begin
               w_cnt_d = r_cnt - CNT_ONE;
            end
         end
         StRun: begin
            if (w_dis_req) begin
               w_state_d = StStop;
               w_cnt_d   = SETTLE_LOAD;
            end else if (w_wr_kick) begin
               w_state_d = StKick;
               w_cnt_d   = LIVE_LOAD;
            end
         end
         StKick: begin
            if (w_dis_req) begin
               w_state_d = StStop;
               w_cnt_d   = SETTLE_LOAD;
            end else if (w_wr_kick) begin
               w_cnt_d = LIVE_LOAD;
            end else if (r_cnt == CNT_ONE) begin
               w_state_d = StRun;
            end else begin
               w_cnt_d = r_cnt - CNT_ONE;
            end
         end
         StStop: begin
            if (w_en_req) begin
               w_pend_en_d = 1'b1;
            end
            if (r_cnt == CNT_ONE) begin
               w_state_d = StDis;
            end else begin
               w_cnt_d = r_cnt - CNT_ONE;
            end
         end
         default: begin
            w_state_d = StDis;
            w_cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      w_code = 2'd0;
      w_busy = 1'b0;
      case (r_state)
         StArm: begin
            w_code = 2'd1;
            w_busy = 1'b1;
         end
         StRun: w_code = 2'd2;
         StKick: begin
            w_code = 2'd3;
            w_busy = 1'b1;
         end
         StStop: begin
            w_code = 2'd1;
            w_busy = 1'b1;
         end
         default: w_code = 2'd0;
      endcase
   end

   // Timer-facing outputs come straight from flops so clk2 never sees req glitches
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wden   <= 1'b0;
         r_wdlive <= 1'b0;
         r_tocnt  <= '0;
      end else begin
         r_wden   <= (w_state_d == StArm) || (w_state_d == StRun) || (w_state_d == StKick);
         r_wdlive <= (w_state_d == StKick);
         if (w_wr_tocnt && (r_state == StDis)) begin
            r_tocnt <= wdata;
         end
      end
   end

   // WTO synchronizer and rising-edge detect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_wto_prev <= 1'b0;
      end else begin
         r_sync1    <= wto_in;
         r_sync2    <= r_sync1;
         r_wto_prev <= r_sync2;
      end
   end

   assign w_wto_rise = r_sync2 & ~r_wto_prev;
   assign w_cfg_set  = (w_wr_tocnt & (r_state != StDis)) | w_lock_viol;

   // Sticky flags: a same-cycle set beats the W1C
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sticky  <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_sticky  <= w_wto_rise | (r_sticky & ~(w_wr_status & wdata[0]));
         r_cfg_err <= w_cfg_set | (r_cfg_err & ~(w_wr_status & wdata[2]));
      end
   end

   always_comb begin
      w_rdata = '0;
      if (!we) begin
         case (addr)
            ADDR_CTRL:   w_rdata[0] = r_wden;
            ADDR_TOCNT:  w_rdata    = r_tocnt;
            ADDR_STATUS: w_rdata    = {26'd0, w_lock, w_code, r_cfg_err, w_busy, r_sticky};
            default:     w_rdata    = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ack   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ack   <= req;
         r_rdata <= req ? w_rdata : '0;
      end
   end

   assign ack    = r_ack;
   assign rdata  = r_rdata;
   assign WDEN   = r_wden;
   assign WDLIVE = r_wdlive;
   assign WTOCNT = r_tocnt;
   assign irq    = r_sticky;

endmodule

// File: tb/tb_wdt_ctrl.sv
// tb_wdt_ctrl: directed self-checking bench for wdt_ctrl (LIVE_HOLD=16, SETTLE=8).
module tb_wdt_ctrl;

   localparam logic [3:0] A_CTRL  = 4'h0;
   localparam logic [3:0] A_KICK  = 4'h4;
   localparam logic [3:0] A_TOCNT = 4'h8;
   localparam logic [3:0] A_STAT  = 4'hC;
`ifdef WDT_LOCK_EN
   localparam logic [31:0] LK = 32'h20;
`else
   localparam logic [31:0] LK = 32'h0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        we;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;
   logic        wto_in;
   logic        WDEN;
   logic        WDLIVE;
   logic [31:0] WTOCNT;
   logic        irq;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   wdt_ctrl #(
      .LIVE_HOLD(16),
      .SETTLE   (8)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .ack   (ack),
      .rdata (rdata),
      .wto_in(wto_in),
      .WDEN  (WDEN),
      .WDLIVE(WDLIVE),
      .WTOCNT(WTOCNT),
      .irq   (irq)
   );

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      req = 1'b0; we = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = a; wdata = '0;
      @(negedge clk);
      d = rdata;
      req = 1'b0;
   endtask

   // Kick once (optionally again 10 cycles later) and count WDLIVE-high cycles
   task automatic kick_run(input bit second, output int hi);
      hi = 0;
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = A_KICK; wdata = 32'h1;
      @(negedge clk);
      req = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         if (WDLIVE) hi++;
         if (second && c == 10) begin
            req = 1'b1; we = 1'b1; addr = A_KICK; wdata = 32'h1;
         end
         if (c == 11) req = 1'b0;
         @(negedge clk);
      end
      we = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wto_in = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({ack, WDEN, WDLIVE, irq, WTOCNT, rdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got ack=%b en=%b live=%b irq=%b tocnt=%h rdata=%h want all 0",
                  ack, WDEN, WDLIVE, irq, WTOCNT, rdata);
      end
      rst = 1'b0;
      bus_read(A_STAT, d);
      checks++;
      if (d !== 32'h0) begin
         errors++; $display("FAIL reset_status: got %h want 00000000", d);
      end
      bus_read(A_CTRL, d);
      checks++;
      if (d !== 32'h0) begin
         errors++; $display("FAIL reset_ctrl: got %h want 00000000", d);
      end
   endtask

   task automatic test_undefined();
      logic [31:0] d;
      bus_write(4'h2, 32'hFFFF_FFFF);
      checks++;
      if (ack !== 1'b1 || rdata !== 32'h0) begin
         errors++; $display("FAIL undef_write_ack: got ack=%b rdata=%h want 1/0", ack, rdata);
      end
      bus_read(4'h2, d);
      checks++;
      if (d !== 32'h0) begin
         errors++; $display("FAIL undef_read: got %h want 00000000", d);
      end
      bus_read(A_STAT, d);
      checks++;
      if (d !== 32'h0) begin
         errors++; $display("FAIL undef_no_effect: got %h want 00000000", d);
      end
   endtask

   task automatic test_enable();
      logic [31:0] st [0:8];
      logic [31:0] d;
      int          busy_n;
      bus_write(A_TOCNT, 32'h0000_1000);
      checks++;
      if (ack !== 1'b1) begin
         errors++; $display("FAIL tocnt_ack: got %b want 1", ack);
      end
      @(negedge clk);
      checks++;
      if (WTOCNT !== 32'h0000_1000 || ack !== 1'b0) begin
         errors++; $display("FAIL tocnt_out: got %h ack=%b want 00001000 ack=0", WTOCNT, ack);
      end
      bus_read(A_TOCNT, d);
      checks++;
      if (d !== 32'h0000_1000) begin
         errors++; $display("FAIL tocnt_read: got %h want 00001000", d);
      end
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = A_CTRL; wdata = 32'h1;
      @(negedge clk);
      checks++;
      if (WDEN !== 1'b1) begin
         errors++; $display("FAIL enable_wden: got %b want 1", WDEN);
      end
      we = 1'b0; addr = A_STAT;
      busy_n = 0;
      for (int i = 0; i <= 8; i++) begin
         @(negedge clk);
         st[i] = rdata;
         if ((st[i] & 32'h1E) == 32'h0A) busy_n++;
      end
      req = 1'b0;
      checks++;
      if (busy_n != 8) begin
         errors++; $display("FAIL arm_busy_cycles: got %0d want 8", busy_n);
      end
      checks++;
      if (st[8] !== (32'h10 | LK)) begin
         errors++; $display("FAIL arm_to_run: got %h want %h", st[8], 32'h10 | LK);
      end
   endtask

   task automatic test_kick();
      int          hi;
      logic [31:0] d;
      kick_run(1'b0, hi);
      checks++;
      if (hi != 16) begin
         errors++; $display("FAIL kick_hold: got %0d cycles want 16", hi);
      end
      kick_run(1'b1, hi);
      checks++;
      if (hi != 26) begin
         errors++; $display("FAIL kick_reload: got %0d cycles want 26", hi);
      end
      bus_read(A_STAT, d);
      checks++;
      if (d !== (32'h10 | LK)) begin
         errors++; $display("FAIL kick_back_to_run: got %h want %h", d, 32'h10 | LK);
      end
   endtask

   task automatic test_cfg_err();
      logic [31:0] d;
      bus_write(A_TOCNT, 32'h55);
      @(negedge clk);
      checks++;
      if (WTOCNT !== 32'h0000_1000) begin
         errors++; $display("FAIL cfg_tocnt_kept: got %h want 00001000", WTOCNT);
      end
      bus_read(A_STAT, d);
      checks++;
      if (d !== (32'h14 | LK)) begin
         errors++; $display("FAIL cfg_err_set: got %h want %h", d, 32'h14 | LK);
      end
      bus_write(A_STAT, 32'h4);
      bus_read(A_STAT, d);
      checks++;
      if (d !== (32'h10 | LK)) begin
         errors++; $display("FAIL cfg_err_clr: got %h want %h", d, 32'h10 | LK);
      end
   endtask

   task automatic test_wto();
      logic [31:0] d;
      int          n;
      @(negedge clk);
      wto_in = 1'b1;
      n = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (irq === 1'b1) begin
            n = c;
            break;
         end
      end
      checks++;
      if (n != 3) begin
         errors++; $display("FAIL wto_latency: got %0d cycles want 3", n);
      end
      repeat (20 - n) @(negedge clk);
      wto_in = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (irq !== 1'b1) begin
         errors++; $display("FAIL irq_sticky: got %b want 1", irq);
      end
      bus_read(A_STAT, d);
      checks++;
      if (d !== (32'h11 | LK)) begin
         errors++; $display("FAIL wto_status: got %h want %h", d, 32'h11 | LK);
      end
      bus_write(A_STAT, 32'h1);
      checks++;
      if (irq !== 1'b0) begin
         errors++; $display("FAIL irq_w1c: got %b want 0", irq);
      end
      // Rising edge reaches the detector on the same edge that takes the W1C
      @(negedge clk);
      wto_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = A_STAT; wdata = 32'h1;
      @(negedge clk);
      req = 1'b0; we = 1'b0;
      checks++;
      if (irq !== 1'b1) begin
         errors++; $display("FAIL irq_set_wins: got %b want 1", irq);
      end
      wto_in = 1'b0;
      repeat (4) @(negedge clk);
      bus_write(A_STAT, 32'h1);
      bus_read(A_STAT, d);
      checks++;
      if (irq !== 1'b0 || d !== (32'h10 | LK)) begin
         errors++; $display("FAIL irq_final_clr: got irq=%b st=%h want 0/%h", irq, d, 32'h10 | LK);
      end
   endtask

`ifdef WDT_LOCK_EN
   task automatic test_lock();
      logic [31:0] d;
      bus_write(A_CTRL, 32'h0);
      @(negedge clk);
      checks++;
      if (WDEN !== 1'b1) begin
         errors++; $display("FAIL lock_ignore_dis: got WDEN=%b want 1", WDEN);
      end
      bus_read(A_STAT, d);
      checks++;
      if (d !== 32'h34) begin
         errors++; $display("FAIL lock_status: got %h want 00000034", d);
      end
      bus_write(A_STAT, 32'h4);
   endtask
`else
   task automatic test_stop();
      logic [31:0] st [0:8];
      int          stop_n;
      bus_write(A_KICK, 32'h1);
      checks++;
      if (WDLIVE !== 1'b1) begin
         errors++; $display("FAIL stop_in_kick: got WDLIVE=%b want 1", WDLIVE);
      end
      bus_write(A_CTRL, 32'h0);
      checks++;
      if (WDLIVE !== 1'b0 || WDEN !== 1'b0) begin
         errors++; $display("FAIL stop_drop: got live=%b en=%b want 0/0", WDLIVE, WDEN);
      end
      req = 1'b1; we = 1'b0; addr = A_STAT;
      stop_n = 0;
      for (int i = 0; i <= 8; i++) begin
         @(negedge clk);
         st[i] = rdata;
         if (st[i] == 32'h0A && WDEN == 1'b0) stop_n++;
      end
      req = 1'b0;
      checks++;
      if (stop_n != 8) begin
         errors++; $display("FAIL stop_cycles: got %0d want 8", stop_n);
      end
      checks++;
      if (st[8] !== 32'h0) begin
         errors++; $display("FAIL stop_to_dis: got %h want 00000000", st[8]);
      end
   endtask

   task automatic test_stop_pending();
      logic [31:0] st [0:7];
      logic        wd [0:7];
      bus_write(A_CTRL, 32'h1);
      repeat (10) @(negedge clk);
      bus_write(A_CTRL, 32'h0);
      bus_write(A_CTRL, 32'h1);
      req = 1'b1; we = 1'b0; addr = A_STAT;
      for (int i = 0; i <= 7; i++) begin
         @(negedge clk);
         st[i] = rdata;
         wd[i] = WDEN;
      end
      req = 1'b0;
      checks++;
      if (st[5] !== 32'h0A || wd[5] !== 1'b0) begin
         errors++; $display("FAIL pend_stop_end: got st=%h en=%b want 0000000a/0", st[5], wd[5]);
      end
      checks++;
      if (st[6] !== 32'h0) begin
         errors++; $display("FAIL pend_dis_one: got %h want 00000000", st[6]);
      end
      checks++;
      if (st[7] !== 32'h0A || wd[6] !== 1'b1) begin
         errors++; $display("FAIL pend_rearm: got st=%h en=%b want 0000000a/1", st[7], wd[6]);
      end
   endtask
`endif

   task automatic test_reset_mid_kick();
      logic [31:0] d;
      repeat (12) @(negedge clk);
      wto_in = 1'b1;
      repeat (5) @(negedge clk);
      wto_in = 1'b0;
      bus_write(A_KICK, 32'h1);
      checks++;
      if (WDLIVE !== 1'b1 || irq !== 1'b1 || WTOCNT !== 32'h0000_1000) begin
         errors++; $display("FAIL rstk_pre: got live=%b irq=%b tocnt=%h want 1/1/00001000",
                            WDLIVE, irq, WTOCNT);
      end
      req = 1'b1; we = 1'b0; addr = A_STAT;
      @(negedge clk);
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if ({ack, WDEN, WDLIVE, irq, WTOCNT} !== '0) begin
         errors++; $display("FAIL rstk_async: got ack=%b en=%b live=%b irq=%b tocnt=%h want all 0",
                            ack, WDEN, WDLIVE, irq, WTOCNT);
      end
      @(negedge clk);
      req = 1'b0;
      rst = 1'b0;
      bus_read(A_STAT, d);
      checks++;
      if (d !== 32'h0) begin
         errors++; $display("FAIL rstk_status: got %h want 00000000", d);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time bound");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_undefined();
      test_enable();
      test_kick();
      test_cfg_err();
      test_wto();
`ifdef WDT_LOCK_EN
      test_lock();
`else
      test_stop();
      test_stop_pending();
`endif
      test_reset_mid_kick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
